sccb_target: RTL and testbench
==============================

# sccb_target

SCCB/I2C target (responder) modelling the OV7670 register file: the far end of the command path that the camera driver drives through the I2C master. It decodes START/STOP, device ID, sub-address and data bytes from sampled SIO_C/SIO_D and ACKs writes. It stores writes in a 256×8 register file and serves reads. It is used as a synthesizable camera stand-in on the Basys3 board and as the bus model in driver testbenches.

## Interface
- `DEV_ADDR`, 7'h21: 7-bit device address (write ID 0x42, read ID 0x43).
- `SYNC_STAGES`, 2: synchronizer depth on `scl_i`/`sda_i` (≥2).
- `clk` in 1: system clock (100 MHz); must be ≥16× SCL rate.
- `reset_` in 1: one clock; reset is synchronous and active-high.
- `scl_i` in 1: raw SIO_C level.
- `sda_i` in 1: raw SIO_D level (wired-AND with `sda_oe`).
- `sda_oe` out 1: 1 = pull SIO_D low; 0 = release.
- `wr_valid` out 1: one-cycle pulse per committed register write.
- `wr_addr` out 8: register address of the commit.
- `wr_data` out 8: data of the commit.
- `busy` out 1: high from START to STOP while addressed.
- `dbg_addr` in 8: debug read address.
- `dbg_data` out 8: combinational register-file contents at `dbg_addr`.

## Operation
- **Reset:** all outputs are 0 and the FSM is IDLE. The address pointer is 0x00. The register file holds its defaults: 0x00 everywhere except 0x0A=0x76 (PID) and 0x0B=0x73 (VER).
- **Line detection:**
  - START is SDA falling while SCL is high (synchronized values).
  - STOP is SDA rising while SCL is high.
  - Bits are sampled on the SCL rising edge, MSB first.
  - `sda_oe` changes only on a detected SCL falling edge.
- **States:** IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_WDATA, RDATA, RACK, WAIT_STOP.
- **START from any state:**
  - The bit counter clears and the FSM enters DEV. This covers repeated START.
  - `busy` is set if the ID matches.
- **STOP from any state:** go to IDLE, release `sda_oe`, clear `busy`.
- **DEV, after 8 bits:**
  - ID[7:1]≠`DEV_ADDR` → WAIT_STOP, no ACK.
  - Write ID → ACK_DEV, then SUB.
  - Read ID → ACK_DEV, then RDATA.
- **ACK phases:** drive `sda_oe`=1 from the falling edge after bit 8 until the next falling edge.
- **SUB:** the 8 bits load the pointer. ACK, then WDATA. A 2-phase write (ID + sub) followed by STOP only sets the pointer.
- **WDATA:**
  - After 8 bits, commit to `reg[ptr]`, pulse `wr_valid` on the cycle of the 8th SCL rise, and ACK.
  - The pointer then increments mod 256 (0xFF→0x00).
  - Further bytes continue in WDATA.
- **Read-only registers 0x0A/0x0B:** writes are ACKed but not stored, and `wr_valid` does not pulse. The pointer still increments.
- **COM7 (0x12) with data bit7=1:**
  - `wr_valid` pulses with the written data.
  - On the following cycle the whole file reloads its defaults, so 0x12 reads 0x00.
- **RDATA:**
  - On each falling edge, `sda_oe` = ~bit, starting at bit 7 of `reg[ptr]` latched at RDATA entry.
  - After 8 bits, release the line and enter RACK.
  - The pointer increments after each byte.
- **RACK:** master ACK (SDA=0) → next byte in RDATA. NACK → WAIT_STOP.
- **`reset_` mid-transfer:** immediate IDLE, `sda_oe`=0, defaults restored. The next transaction requires a fresh START.

## Timing
- Synchronizer latency is `SYNC_STAGES` cycles, plus 1 cycle for edge detection. The sampling point is therefore SCL rise + 3 cycles by default.
- `sda_oe` asserts/deasserts SCL fall + 3 cycles by default, well inside SCL low (≥8 clk at ratio 16).
- `wr_valid` is exactly 1 cycle wide. Consecutive commits are ≥16 clk apart.
- `wr_addr`/`wr_data` hold until the next commit.
- `dbg_data` has zero latency from `dbg_addr` and reflects commits on the cycle after `wr_valid`.
- START and STOP detected on the same cycle cannot occur; STOP is checked first.

## Structure
- `sccb_pkg`:
  - FSM state enum `sccb_state_t`.
  - `SCCB_DEV_ADDR` (7'h21).
  - `REG_PID`/`REG_VER`/`REG_COM7` addresses.
  - PID/VER default values.
  - `reg_is_ro()` function.
- Sub-module `sccb_line_sync`: synchronizers, SCL rise/fall strobes, START/STOP strobes.
- Top: FSM, shift register, bit counter, pointer, register file.

## Test plan
- Write 0x42, 0x3A, 0x55, STOP:
  - three ACKs observed;
  - `wr_valid` once with addr 0x3A, data 0x55;
  - `dbg_data`@0x3A = 0x55.
- Write 0x42, 0x0A, STOP; then 0x43, read 2 bytes (ACK, NACK):
  - returns 0x76, 0x73;
  - SDA released after the NACK.
- Write 0x42, 0xFF, 0x11, 0x22:
  - commits (0xFF,0x11) then (0x00,0x22);
  - pointer wraps.
- ID 0x44, three bytes:
  - no ACK, `sda_oe` never 1, no `wr_valid`, `busy` stays 0.
- Write 0x12←0x80 after 0x3A←0x55:
  - next cycle 0x3A=0x00 and 0x12=0x00;
  - 0x0B=0x73.
- Assert `reset_` mid-WDATA (bit 4):
  - `sda_oe`=0 next cycle, no commit;
  - a following full write succeeds.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM states, device address, OV7670 register map.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_SUB,
        ST_ACK_SUB,
        ST_WDATA,
        ST_ACK_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } sccb_state_t;

    localparam logic [6:0] SCCB_DEV_ADDR = 7'h21;

    localparam logic [7:0] REG_PID  = 8'h0A;
    localparam logic [7:0] REG_VER  = 8'h0B;
    localparam logic [7:0] REG_COM7 = 8'h12;

    localparam logic [7:0] PID_DEFAULT = 8'h76;
    localparam logic [7:0] VER_DEFAULT = 8'h73;

    function automatic logic reg_is_ro(input logic [7:0] addr);
        return (addr == REG_PID) || (addr == REG_VER);
    endfunction

    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        case (addr)
            REG_PID: return PID_DEFAULT;
            REG_VER: return VER_DEFAULT;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/sccb_if.sv
// SCCB line levels, commit strobe and debug read port between bus master/bench and the target.
interface sccb_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;

    modport master (
        output scl_i, sda_i, dbg_addr,
        input  sda_oe, wr_valid, wr_addr, wr_data, busy, dbg_data
    );

    modport slave (
        input  scl_i, sda_i, dbg_addr,
        output sda_oe, wr_valid, wr_addr, wr_data, busy, dbg_data
    );
endinterface

// File: rtl/sccb_line_sync.sv
// Synchronizes raw SCL/SDA and derives SCL edge and START/STOP strobes.
// Latency: STAGES cycles of sync, strobes combinational from the last stage and its delayed copy.
// No backpressure: strobes are single-cycle and must be consumed when raised.
module sccb_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [STAGES-1:0] scl_sr;
    logic [STAGES-1:0] sda_sr;
    logic              scl_q;
    logic              sda_q;
    logic              scl;

    // Reset to the idle-bus level so no phantom edge appears after reset.
    always_ff @(posedge clk) begin
        if (reset_) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[STAGES-2:0], scl_raw};
            sda_sr <= {sda_sr[STAGES-2:0], sda_raw};
            scl_q  <= scl_sr[STAGES-1];
            sda_q  <= sda_sr[STAGES-1];
        end
    end

    assign scl      = scl_sr[STAGES-1];
    assign sda      = sda_sr[STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & ~sda & sda_q;
    assign stop     = scl & scl_q & sda & ~sda_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target emulating the OV7670 register file: decodes ID/sub-address/data, ACKs, serves reads.
// Latency: line events act SYNC_STAGES+1 clk after the raw SCL edge; wr_valid is a 1-cycle commit pulse.
// No backpressure: the bus master sets the pace, SCL must run at most clk/16.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = SCCB_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  reset_,
    sccb_if.slave bus
);
    sccb_state_t state, state_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  ptr, ptr_nxt;
    logic [7:0]  byte_in;
    logic        rnw, rnw_nxt;
    logic        sda_oe, sda_oe_nxt;
    logic        busy, busy_nxt;
    logic        commit, reload_nxt, reload;
    logic        wr_valid;
    logic [7:0]  wr_addr, wr_data;
    logic [7:0]  regs [256];
    logic        sda, scl_rise, scl_fall, start, stop;

    sccb_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset_   (reset_),
        .scl_raw  (bus.scl_i),
        .sda_raw  (bus.sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign byte_in = {shift[6:0], sda};

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        ptr_nxt     = ptr;
        rnw_nxt     = rnw;
        sda_oe_nxt  = sda_oe;
        busy_nxt    = busy;
        commit      = 1'b0;
        reload_nxt  = 1'b0;

        if (stop) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start) begin
            state_nxt   = ST_DEV;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else begin
            case (state)
                ST_DEV, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            case (state)
                                ST_DEV: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_nxt = ST_ACK_DEV;
                                        rnw_nxt   = byte_in[0];
                                        busy_nxt  = 1'b1;
                                    end else begin
                                        state_nxt = ST_WAIT_STOP;
                                    end
                                end
                                ST_SUB: begin
                                    ptr_nxt   = byte_in;
                                    state_nxt = ST_ACK_SUB;
                                end
                                default: begin
                                    commit     = !reg_is_ro(ptr);
                                    reload_nxt = !reg_is_ro(ptr) && (ptr == REG_COM7) && byte_in[7];
                                    ptr_nxt    = ptr + 8'd1;
                                    state_nxt  = ST_ACK_WDATA;
                                end
                            endcase
                        end
                    end
                end
                // First fall after bit 8 pulls SDA low; the next fall releases it and moves on.
                ST_ACK_DEV, ST_ACK_SUB, ST_ACK_WDATA: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 4'd0;
                            if (state == ST_ACK_DEV && rnw) begin
                                state_nxt  = ST_RDATA;
                                shift_nxt  = regs[ptr];
                                sda_oe_nxt = ~regs[ptr][7];
                            end else if (state == ST_ACK_DEV) begin
                                state_nxt = ST_SUB;
                            end else begin
                                state_nxt = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        shift_nxt   = {shift[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                            ptr_nxt    = ptr + 8'd1;
                            state_nxt  = ST_RACK;
                        end else begin
                            sda_oe_nxt = ~shift[7];
                        end
                    end
                end
                // bit_cnt==0 marks a master ACK seen on the 9th rise.
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda) state_nxt = ST_WAIT_STOP;
                        else     bit_cnt_nxt = 4'd0;
                    end else if (scl_fall && bit_cnt == 4'd0) begin
                        state_nxt  = ST_RDATA;
                        shift_nxt  = regs[ptr];
                        sda_oe_nxt = ~regs[ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            ptr      <= 8'h00;
            rnw      <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            reload   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            ptr      <= ptr_nxt;
            rnw      <= rnw_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            reload   <= reload_nxt;
            wr_valid <= commit;
            if (commit) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_ || reload) begin
            for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i));
        end else if (commit) begin
            regs[ptr] <= byte_in;
        end
    end

    assign bus.sda_oe   = sda_oe;
    assign bus.busy     = busy;
    assign bus.wr_valid = wr_valid;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB master, register-file model and per-cycle compare process.
module tb_sccb_target;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset_ = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] dbg_addr = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mreg [256];
    logic [7:0]  mptr = 8'h00;
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];
    logic        oe_forbid = 1'b0;
    logic        peek_on = 1'b0;
    logic [7:0]  peek_addr = 8'h00;

    sccb_if bus ();
    assign bus.scl_i    = scl;
    assign bus.sda_i    = sda_m & ~bus.sda_oe;
    assign bus.dbg_addr = dbg_addr;

    sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [7:0] a);
        if (a == 8'h0A) return 8'h76;
        if (a == 8'h0B) return 8'h73;
        return 8'h00;
    endfunction

    function automatic logic is_ro(input logic [7:0] a);
        return (a == 8'h0A) || (a == 8'h0B);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: commits against the expectation queue, debug port against the model.
    always @(negedge clk) begin
        if (!reset_) begin
            if (bus.wr_valid) begin
                if (exp_q.size() == 0) begin
                    check("wr_valid_unexpected", {31'd0, bus.wr_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e[15:8]});
                    check("wr_data", {24'd0, bus.wr_data}, {24'd0, e[7:0]});
                    mreg[e[15:8]] = e[7:0];
                    if (e[15:8] == 8'h12 && e[7])
                        for (int i = 0; i < 256; i++) mreg[i] = dflt(8'(i));
                end
            end else begin
                check("dbg_data", {24'd0, bus.dbg_data}, {24'd0, mreg[dbg_addr]});
            end
            if (oe_forbid) check("oe_forbid", {31'd0, bus.sda_oe}, 32'd0);
        end
        dbg_addr = peek_on ? peek_addr : 8'($urandom);
    end

    task automatic peek(input logic [7:0] a, output logic [7:0] v);
        peek_addr = a;
        peek_on   = 1'b1;
        tick(2);
        v = bus.dbg_data;
        peek_on = 1'b0;
    endtask

    task automatic do_reset();
        reset_ = 1'b1;
        for (int i = 0; i < 256; i++) mreg[i] = dflt(8'(i));
        mptr = 8'h00;
        exp_q.delete();
        tick(2);
        reset_ = 1'b0;
        tick(1);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;  tick(Q);
        scl = 1'b1; tick(Q);
        s = bus.sda_i;
        tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(nack, s);
    endtask

    // Write ID then n bytes (wbuf[0] is the sub-address), then STOP.
    task automatic wr_txn(input logic [7:0] id, input int n, output int acks);
        logic ack, match;
        match = (id[7:1] == 7'h21) && !id[0];
        acks = 0;
        bus_start();
        send_byte(id, ack);
        acks += int'(ack);
        check("ack_id", {31'd0, ack}, {31'd0, match});
        check("busy_after_id", {31'd0, bus.busy}, {31'd0, match});
        for (int i = 0; i < n; i++) begin
            if (match) begin
                if (i == 0) begin
                    mptr = wbuf[0];
                end else begin
                    if (!is_ro(mptr)) exp_q.push_back({mptr, wbuf[i]});
                    mptr = mptr + 8'd1;
                end
            end
            send_byte(wbuf[i], ack);
            acks += int'(ack);
            check("ack_byte", {31'd0, ack}, {31'd0, match});
            check("busy_in_txn", {31'd0, bus.busy}, {31'd0, match});
        end
        bus_stop();
        check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
        check("oe_after_stop", {31'd0, bus.sda_oe}, 32'd0);
    endtask

    task automatic rd_txn(input int n);
        logic       ack;
        logic [7:0] d, x;
        bus_start();
        send_byte(8'h43, ack);
        check("ack_rd_id", {31'd0, ack}, 32'd1);
        check("busy_rd", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            x = mreg[mptr];
            mptr = mptr + 8'd1;
            read_byte(i == n - 1, d);
            rbuf[i] = d;
            check("rd_data", {24'd0, d}, {24'd0, x});
        end
        check("oe_after_nack", {31'd0, bus.sda_oe}, 32'd0);
        bus_stop();
        check("busy_after_rd", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int         acks, n, kind;
        logic [7:0] v, id;
        logic       s;

        do_reset();
        check("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        check("rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
        peek(8'h0A, v); check("rst_pid", {24'd0, v}, 32'h76);
        peek(8'h0B, v); check("rst_ver", {24'd0, v}, 32'h73);
        peek(8'h00, v); check("rst_r00", {24'd0, v}, 32'h00);

        wbuf[0] = 8'h3A; wbuf[1] = 8'h55;
        wr_txn(8'h42, 2, acks);
        check("t1_acks", acks, 3);
        peek(8'h3A, v); check("t1_dbg_3a", {24'd0, v}, 32'h55);
        check("t1_model_3a", {24'd0, mreg[8'h3A]}, 32'h55);

        wbuf[0] = 8'h0A;
        wr_txn(8'h42, 1, acks);
        rd_txn(2);
        check("t2_pid", {24'd0, rbuf[0]}, 32'h76);
        check("t2_ver", {24'd0, rbuf[1]}, 32'h73);

        wbuf[0] = 8'hFF; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        wr_txn(8'h42, 3, acks);
        peek(8'hFF, v); check("t3_ff", {24'd0, v}, 32'h11);
        peek(8'h00, v); check("t3_00", {24'd0, v}, 32'h22);
        check("t3_model_ptr", {24'd0, mptr}, 32'h01);

        oe_forbid = 1'b1;
        wbuf[0] = 8'h3A; wbuf[1] = 8'h99; wbuf[2] = 8'h77;
        wr_txn(8'h44, 3, acks);
        oe_forbid = 1'b0;
        check("t4_acks", acks, 0);

        wbuf[0] = 8'h3A; wbuf[1] = 8'h55;
        wr_txn(8'h42, 2, acks);
        wbuf[0] = 8'h12; wbuf[1] = 8'h80;
        wr_txn(8'h42, 2, acks);
        peek(8'h3A, v); check("t5_3a", {24'd0, v}, 32'h00);
        peek(8'h12, v); check("t5_12", {24'd0, v}, 32'h00);
        peek(8'h0B, v); check("t5_0b", {24'd0, v}, 32'h73);

        // Reset after bit 4 of a data byte: no commit, line released, fresh write works.
        bus_start();
        send_byte(8'h42, s);
        send_byte(8'h20, s);
        for (int i = 7; i >= 4; i--) clock_bit(v[i] ^ 1'b1, s);
        reset_ = 1'b1;
        for (int i = 0; i < 256; i++) mreg[i] = dflt(8'(i));
        mptr = 8'h00;
        tick(1);
        check("t6_oe", {31'd0, bus.sda_oe}, 32'd0);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        reset_ = 1'b0;
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(2 * Q);
        peek(8'h20, v); check("t6_no_commit", {24'd0, v}, 32'h00);
        wbuf[0] = 8'h21; wbuf[1] = 8'hA5;
        wr_txn(8'h42, 2, acks);
        check("t6_acks", acks, 3);
        peek(8'h21, v); check("t6_dbg_21", {24'd0, v}, 32'hA5);

        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                n = int'($urandom_range(1, 4));
                case ($urandom_range(0, 5))
                    0: wbuf[0] = 8'h0A;
                    1: wbuf[0] = 8'h12;
                    2: wbuf[0] = 8'hFE;
                    default: wbuf[0] = 8'($urandom);
                endcase
                for (int i = 1; i <= n; i++) wbuf[i] = 8'($urandom);
                wr_txn(8'h42, n + 1, acks);
            end else if (kind == 2) begin
                rd_txn(int'($urandom_range(1, 3)));
            end else begin
                id = 8'($urandom) & 8'hFE;
                if (id[7:1] == 7'h21) id = 8'h44;
                for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
                oe_forbid = 1'b1;
                wr_txn(id, 3, acks);
                oe_forbid = 1'b0;
            end
        end

        tick(4);
        check("pending_commits", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
